// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) widths, data-bit positions and nibble extraction
package hamming_pkg;

    localparam int CW_W  = 7;
    localparam int DW    = 4;
    localparam int SYN_W = 3;

    localparam int DPOS3 = 6;
    localparam int DPOS2 = 5;
    localparam int DPOS1 = 4;
    localparam int DPOS0 = 2;

    function automatic logic [DW-1:0] hamming_data(input logic [CW_W-1:0] code);
        return {code[DPOS3], code[DPOS2], code[DPOS1], code[DPOS0]};
    endfunction

endpackage

// File: rtl/hamming_det.sv
// rtl/hamming_det.sv - Hamming(7,4) syndrome computation and single-bit correction
module hamming_det
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  code_i,
    output logic [SYN_W-1:0] syn_o,
    output logic [CW_W-1:0]  corr_code_o
);

    logic [CW_W-1:0] flip;

    assign syn_o[0] = code_i[0] ^ code_i[2] ^ code_i[4] ^ code_i[6];
    assign syn_o[1] = code_i[1] ^ code_i[2] ^ code_i[5] ^ code_i[6];
    assign syn_o[2] = code_i[3] ^ code_i[4] ^ code_i[5] ^ code_i[6];

    // Syndrome is position+1 of the flipped bit; double errors land on a wrong bit.
    assign flip        = (syn_o != '0) ? (CW_W'(1) << (syn_o - SYN_W'(1))) : '0;
    assign corr_code_o = code_i ^ flip;

endmodule

// File: rtl/hamming_dec_arbiter.sv
// rtl/hamming_dec_arbiter.sv - round-robin shared Hamming(7,4) decoder with link statistics
module hamming_dec_arbiter
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [CW_W*NUM_REQ-1:0] req_code,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW_W-1:0]         out_code,
    output logic [DW-1:0]           out_data,
    output logic [SYN_W-1:0]        out_syn,
    output logic                    out_corr,
    output logic [ID_W-1:0]         out_id,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        cnt_words,
    output logic [CNT_W-1:0]        cnt_corr
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   last_q;
    logic              load;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   gidx;
    logic              any_grant;
    logic [CW_W-1:0]   sel_code;
    logic [SYN_W-1:0]  det_syn;
    logic [CW_W-1:0]   det_code;

    assign load = (state_q == EMPTY) | out_ready;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!any_grant && load && rst_n && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_code  = req_code[CW_W*int'(gidx) +: CW_W];

    hamming_det u_det (
        .code_i      (sel_code),
        .syn_o       (det_syn),
        .corr_code_o (det_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_data  <= '0;
            out_syn   <= '0;
            out_corr  <= 1'b0;
            out_id    <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (any_grant) begin
                        state_q   <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready && !any_grant) begin
                        state_q   <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
            if (any_grant) begin
                out_code <= det_code;
                out_data <= hamming_data(det_code);
                out_syn  <= det_syn;
                out_corr <= (det_syn != '0);
                out_id   <= gidx;
                last_q   <= gidx;
            end
        end
    end

    // Clear wins over a same-cycle accept, so that word is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_words <= '0;
            cnt_corr  <= '0;
        end else if (cnt_clr) begin
            cnt_words <= '0;
            cnt_corr  <= '0;
        end else if (any_grant) begin
            if (cnt_words != '1) cnt_words <= cnt_words + CNT_W'(1);
            if (det_syn != '0 && cnt_corr != '1) cnt_corr <= cnt_corr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// tb/tb_hamming_dec_arbiter.sv - directed self-checking bench for hamming_dec_arbiter
module tb_hamming_dec_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req_valid;
    logic [7*NUM_REQ-1:0] req_code;
    logic [NUM_REQ-1:0] req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [6:0]         out_code;
    logic [3:0]         out_data;
    logic [2:0]         out_syn;
    logic               out_corr;
    logic [ID_W-1:0]    out_id;
    logic               cnt_clr;
    logic [CNT_W-1:0]   cnt_words;
    logic [CNT_W-1:0]   cnt_corr;

    int n_assert = 0;
    int n_fail   = 0;

    hamming_dec_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_data  (out_data),
        .out_syn   (out_syn),
        .out_corr  (out_corr),
        .out_id    (out_id),
        .cnt_clr   (cnt_clr),
        .cnt_words (cnt_words),
        .cnt_corr  (cnt_corr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean codewords: req0=00, req1=55, req2=7F, req3=2A
    logic [6:0] clean_tab [NUM_REQ];
    logic [3:0] data_tab  [NUM_REQ];

    initial begin
        clean_tab[0] = 7'h00; data_tab[0] = 4'b0000;
        clean_tab[1] = 7'h55; data_tab[1] = 4'b1011;
        clean_tab[2] = 7'h7F; data_tab[2] = 4'b1111;
        clean_tab[3] = 7'h2A; data_tab[3] = 4'b0100;

        rst_n     = 1'b0;
        req_valid = '1;
        req_code  = {clean_tab[3], clean_tab[2], clean_tab[1], clean_tab[0]};
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cnt_words", 32'(cnt_words), 32'd0);
        chk("rst_out_code",  32'(out_code),  32'd0);

        // Round robin from reset: 0,1,2,3,0,1
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_id",    32'(out_id),    32'(k % 4));
            chk("rr_out_code",  32'(out_code),  32'(clean_tab[k % 4]));
            chk("rr_out_data",  32'(out_data),  32'(data_tab[k % 4]));
        end
        chk("rr_cnt_words", 32'(cnt_words), 32'd6);
        chk("rr_cnt_corr",  32'(cnt_corr),  32'd0);

        // Asynchronous reset while holding a result
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt_words", 32'(cnt_words), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Clean word from requester 1 (rr pointer back to 3, so 1 wins alone)
        req_valid = 4'b0010;
        req_code  = {7'h00, 7'h00, 7'h55, 7'h00};
        #1;
        chk("clean_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("clean_out_valid", 32'(out_valid), 32'd1);
        chk("clean_out_code",  32'(out_code),  32'h55);
        chk("clean_out_data",  32'(out_data),  32'b1011);
        chk("clean_out_syn",   32'(out_syn),   32'd0);
        chk("clean_out_corr",  32'(out_corr),  32'd0);
        chk("clean_out_id",    32'(out_id),    32'd1);
        chk("clean_cnt_words", 32'(cnt_words), 32'd1);
        chk("clean_cnt_corr",  32'(cnt_corr),  32'd0);

        // Single-bit error: bit 4 of 7'h55 flipped
        req_valid = 4'b0100;
        req_code  = {7'h00, 7'h45, 7'h00, 7'h00};
        #1;
        chk("err_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("err_out_syn",   32'(out_syn),   32'd5);
        chk("err_out_code",  32'(out_code),  32'h55);
        chk("err_out_data",  32'(out_data),  32'b1011);
        chk("err_out_corr",  32'(out_corr),  32'd1);
        chk("err_out_id",    32'(out_id),    32'd2);
        chk("err_cnt_words", 32'(cnt_words), 32'd2);
        chk("err_cnt_corr",  32'(cnt_corr),  32'd1);

        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: last winner was 2, so 3 is next
        req_code  = {clean_tab[3], clean_tab[2], clean_tab[1], clean_tab[0]};
        req_valid = '1;
        out_ready = 1'b0;
        #1;
        chk("bp_first_grant", 32'(req_ready), 32'b1000);
        tick();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_id",    32'(out_id),    32'd3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_id",    32'(out_id),    32'd3);
            chk("bp_hold_code",  32'(out_code),  32'h2A);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("bp_next_id",    32'(out_id),    32'd0);
        chk("bp_cnt_words",  32'(cnt_words), 32'd4);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);

        // Clear, then saturate with 20 corrected words (7'h54 has syndrome 1)
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt_words", 32'(cnt_words), 32'd0);
        chk("clr_cnt_corr",  32'(cnt_corr),  32'd0);
        req_code  = {7'h00, 7'h00, 7'h00, 7'h54};
        req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_cnt_words", 32'(cnt_words), 32'd15);
        chk("sat_cnt_corr",  32'(cnt_corr),  32'd15);
        chk("sat_out_syn",   32'(out_syn),   32'd1);
        chk("sat_out_code",  32'(out_code),  32'h55);

        // Clear coinciding with an accept: word not counted
        cnt_clr = 1'b1;
        #1;
        chk("clr_acc_grant", 32'(req_ready), 32'b0001);
        tick();
        cnt_clr = 1'b0;
        chk("clr_acc_words", 32'(cnt_words), 32'd0);
        chk("clr_acc_corr",  32'(cnt_corr),  32'd0);
        chk("clr_acc_valid", 32'(out_valid), 32'd1);
        tick();
        req_valid = '0;
        chk("post_clr_words", 32'(cnt_words), 32'd1);
        chk("post_clr_corr",  32'(cnt_corr),  32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
